// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS32 iterative multiply/divide unit:
// operation encodings, FSM state type and a conditional-negate helper.
package mips_muldiv_pkg;

  // Encodings of the op input
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Widest operand the helper below handles; callers cast in and out of it
  localparam int MAX_WIDTH = 64;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Two's-complement magnitude when 'negative' is the value's sign bit;
  // used as a plain conditional negate for the result sign fix as well.
  function automatic logic [MAX_WIDTH-1:0] magnitude(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 negative);
    return negative ? -value : value;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// The 2*WIDTH accumulator is shared: for multiply it is {partial product
// high half, remaining multiplier bits}; for divide it is {partial
// remainder, dividend bits shifting out / quotient bits shifting in}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = acc;
    if (!is_div) begin
      // Add the multiplicand into the high half when the current multiplier
      // bit is set, then shift the whole accumulator right by one.
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      // Bring the next dividend bit into the partial remainder and try to
      // subtract the divisor; keep the old value if the result goes negative.
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = shifted - {1'b0, operand};
      if (diff[WIDTH]) begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are converted to magnitudes on accept, WIDTH radix-2 steps run
// in MUL or DIV, and FIX applies the sign correction and writes HI/LO.
// Accept-to-done latency is fixed at WIDTH+2 edges. WIDTH must be even,
// at least 4 and at most 64.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  import mips_muldiv_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t state;
  state_t state_next;

  logic accept;
  logic iterate;
  logic fix_write;

  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand_q;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div_zero_q;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_q),
    .acc      (acc),
    .operand  (operand_q),
    .acc_next (acc_step)
  );

  // Decode the requested operation and take operand magnitudes for signed ops
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_mag     = op_signed ? WIDTH'(magnitude(MAX_WIDTH'(operand_a), operand_a[WIDTH-1]))
                          : operand_a;
    b_mag     = op_signed ? WIDTH'(magnitude(MAX_WIDTH'(operand_b), operand_b[WIDTH-1]))
                          : operand_b;
  end

  // State register
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; MUL/DIV spend one cycle past the last step so that
  // done lands exactly WIDTH+2 edges after accept
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_next = op_div ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == LAST_CNT) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control outputs derived from the current state
  always_comb begin
    busy      = (state != IDLE);
    accept    = (state == IDLE) && start && !flush;
    iterate   = ((state == MUL) || (state == DIV)) && !flush && (cnt != LAST_CNT);
    fix_write = (state == FIX) && !flush;
  end

  // Working registers: load on accept, one radix-2 step per busy cycle
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      acc        <= '0;
      operand_q  <= '0;
      cnt        <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= fix_write;
      if (accept) begin
        div_q      <= op_div;
        neg_res_q  <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        neg_rem_q  <= op_signed && operand_a[WIDTH-1];
        div_zero_q <= (operand_b == '0);
        cnt        <= '0;
        if (op_div) begin
          acc       <= {{WIDTH{1'b0}}, a_mag};
          operand_q <= b_mag;
        end else begin
          acc       <= {{WIDTH{1'b0}}, b_mag};
          operand_q <= a_mag;
        end
      end else if (iterate) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Sign correction of the finished magnitudes. A zero divisor leaves the
  // dividend magnitude as remainder, which the dividend-sign fix turns
  // back into operand_a; the quotient is forced to all ones.
  always_comb begin
    prod_fix = neg_res_q ? -acc : acc;
    quo_fix  = div_zero_q ? '1
                          : WIDTH'(magnitude(MAX_WIDTH'(acc[WIDTH-1:0]), neg_res_q));
    rem_fix  = WIDTH'(magnitude(MAX_WIDTH'(acc[2*WIDTH-1:WIDTH]), neg_rem_q));
    if (div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // HI/LO: written by a completed operation, or by MTHI/MTLO while idle
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_write) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (state == IDLE) begin
      if (hi_we) begin
        hi_q <= wr_data;
      end
      if (lo_we) begin
        lo_q <= wr_data;
      end
    end
  end

  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32 main instance plus a
// WIDTH=8 instance). Expected HI/LO come from plain integer arithmetic.
module tb_mips_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneEdge;
  } exp_t;

  logic clock = 1'b0;
  logic Reset = 1'b0;

  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  logic       start8 = 1'b0;
  logic [1:0] op8 = 2'b00;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       flush8 = 1'b0;
  logic       hiWe8 = 1'b0;
  logic       loWe8 = 1'b0;
  logic [7:0] wrData8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] hi8;
  logic [7:0] lo8;

  int vectorsApplied = 0;
  int miscompares = 0;
  int edgeCount = 0;
  exp_t expQ[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .Reset     (Reset),
    .start     (start8),
    .op        (op8),
    .operand_a (a8),
    .operand_b (b8),
    .flush     (flush8),
    .hi_we     (hiWe8),
    .lo_we     (loWe8),
    .wr_data   (wrData8),
    .busy      (busy8),
    .done      (done8),
    .hi_out    (hi8),
    .lo_out    (lo8)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Edge counter used to time-stamp expected done pulses
  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Architectural result of one operation at width w, from integer arithmetic
  function automatic void refModel(input int w, input logic [1:0] opIn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    p = 0; q = 0; r = 0;
    case (opIn)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = ua * ub;
      OP_DIV:   if (ub != 0) begin q = sa / sb; r = sa % sb; end
      default:  if (ub != 0) begin q = ua / ub; r = ua % ub; end
    endcase
    if (opIn == OP_MULT || opIn == OP_MULTU) begin
      hi = 32'((p >> w) & mask);
      lo = 32'(p & mask);
    end else if (ub == 0) begin
      hi = 32'(ua);
      lo = 32'(mask);
    end else begin
      hi = 32'(r & mask);
      lo = 32'(q & mask);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Issue one operation at a negedge; tracked ops go to the scoreboard
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, input bit track);
    exp_t e;
    start     = 1'b1;
    op        = opIn;
    operand_a = a;
    operand_b = b;
    if (track) begin
      refModel(32, opIn, a, b, e.hi, e.lo);
      e.doneEdge = edgeCount + 35;
      expQ.push_back(e);
      modelHi = e.hi;
      modelLo = e.lo;
    end
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clock);
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  // Monitor: every done pulse retires the oldest expected result
  always @(negedge clock) begin
    exp_t e;
    if (Reset === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 32'(done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("hi", hi_out, e.hi);
        checkOutput("lo", lo_out, e.lo);
        checkOutput("doneEdge", 32'(edgeCount), 32'(e.doneEdge));
        checkOutput("busyInDone", 32'(busy), 32'd0);
      end
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random sequence
  initial begin
    logic [31:0] a, b, eh, el;
    logic [1:0]  o;
    int          sel, lat;

    #2;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetHi", hi_out, 32'd0);
    checkOutput("resetLo", lo_out, 32'd0);
    @(negedge clock);
    @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);

    $display("[TB] directed operations");
    applyStimulus(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b1); waitDrain();
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1); waitDrain();
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1); waitDrain();
    applyStimulus(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b1); waitDrain();
    applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDrain();
    applyStimulus(OP_DIV,   32'h8000_0001, 32'h0000_0000, 1'b1); waitDrain();

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = 32'($urandom_range(0, 100));
      applyStimulus(o, a, b, 1'b1);
      waitDrain();
    end

    $display("[TB] flush");
    hi_we   = 1'b1;
    wr_data = 32'h1234_5678;
    @(negedge clock);
    hi_we = 1'b0;
    modelHi = 32'h1234_5678;
    checkOutput("mthi", hi_out, modelHi);
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 1'b0);
    repeat (8) @(negedge clock);
    checkOutput("busyBeforeFlush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("busyAfterFlush", 32'(busy), 32'd0);
    repeat (40) @(negedge clock);
    checkOutput("flushHiKept", hi_out, modelHi);
    checkOutput("flushLoKept", lo_out, modelLo);
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 1'b1);
    waitDrain();

    $display("[TB] disturbances while busy");
    applyStimulus(OP_DIV, 32'd1000, 32'd7, 1'b1);
    repeat (3) @(negedge clock);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd5; operand_b = 32'd6;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("hiHeldBusy", hi_out, 32'd0);
    repeat (10) @(negedge clock);
    start = 1'b1; op = OP_DIV;
    @(negedge clock);
    start = 1'b0;
    waitDrain();

    $display("[TB] MT write together with start");
    hi_we   = 1'b1;
    wr_data = 32'hAAAA_5555;
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0009, 1'b1);
    hi_we = 1'b0;
    checkOutput("mtWithStart", hi_out, 32'hAAAA_5555);
    waitDrain();

    $display("[TB] reset mid-divide");
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clock);
    #2 Reset = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstDone", 32'(done), 32'd0);
    checkOutput("asyncRstHi", hi_out, 32'd0);
    checkOutput("asyncRstLo", lo_out, 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    repeat (40) @(negedge clock);
    checkOutput("postRstHi", hi_out, 32'd0);

    $display("[TB] WIDTH=8 instance");
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
      end else begin
        op8 = 2'($urandom_range(0, 3));
        a8  = 8'($urandom);
        b8  = (i == 3) ? 8'h00 : 8'($urandom);
      end
      refModel(8, op8, 32'(a8), 32'(b8), eh, el);
      start8 = 1'b1;
      @(posedge clock);
      #1 start8 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clock);
        @(negedge clock);
        if (done8) begin
          lat = k;
          break;
        end
      end
      checkOutput("w8Latency", 32'(lat), 32'd10);
      checkOutput("w8Hi", 32'(hi8), eh);
      checkOutput("w8Lo", 32'(lo8), el);
      @(negedge clock);
    end

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS32 pipelined core; executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Sits beside the EX-stage ALU. While it is busy, the hazard logic stalls any MFHI/MFLO or new mul/div instruction.
- Parametrised successor of the fixed single-cycle 32-bit datapath: width is generic, operations are multi-cycle, and there is a busy/done handshake and an abort.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits (even, >= 4).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  in  WIDTH  rs value (multiplicand or dividend).
- operand_b  in  WIDTH  rt value (multiplier or divisor).
- flush  in  1  abort the current operation (branch or exception flush).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; the pipeline must stall dependent instructions.
- done  out  1  one-cycle pulse; HI/LO were updated this cycle.
- hi_out  out  WIDTH  HI register (remainder or upper product).
- lo_out  out  WIDTH  LO register (quotient or lower product).

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; busy=0, done=0, hi_out=0, lo_out=0; counter and working registers cleared. Reset applied mid-operation discards the operation immediately.
- States:
  - IDLE --start&!flush--> MUL or DIV (selected by op[1]).
  - MUL/DIV: one radix-2 step per cycle, WIDTH cycles, then FIX.
  - FIX: sign correction and HI/LO write, then IDLE.
  - flush=1 in MUL, DIV or FIX -> IDLE. No HI/LO write, no done.
- Accept edge: latch op. For signed ops take magnitudes of the operands; record result sign (a^b) and remainder sign (a).
- MUL step: shift-add into a 2*WIDTH accumulator.
- DIV step: restoring shift-subtract. Remainder is WIDTH+1 bits.
- Timing:
  - busy=1 from the edge after accept until done asserts.
  - done=1 for exactly one cycle, WIDTH+2 edges after the accept edge; busy=0 in that cycle.
  - hi_out/lo_out show the new values in the same cycle as done.
- start in IDLE together with flush: ignored.
- start while busy: ignored. The pipeline must not issue it.
- Signed result fix:
  - product negated in 2*WIDTH bits if the signs differ;
  - quotient negated if the signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero (any DIV/DIVU with operand_b=0): LO = all ones, HI = operand_a. Full latency still applies.
- Signed overflow (DIV of most-negative by -1): LO = most-negative value, HI = 0. This is the natural wrap, not special-cased.
- hi_we/lo_we:
  - honoured only in IDLE (including the done cycle, since state is then IDLE); they update the register on the next edge;
  - ignored while busy.
- hi_we/lo_we together with start in IDLE: the write lands first; the operation's result overwrites it at completion.
- hi_out/lo_out are held unchanged during an operation; only FIX or an MT write updates them.

Decomposition:
- Shared package mips_muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, MUL, DIV, FIX;
  - a function giving the 2's-complement magnitude.
- One combinational sub-module, muldiv_step: the single-iteration shift-add / shift-subtract datapath, parametrised by WIDTH. The FSM, counter and HI/LO registers stay in mips_muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> after 34 edges done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007, done still at edge 34.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, no X, single done pulse.
- Preload HI=0x12345678 via hi_we. Start MULTU 3*5. Assert flush at cycle 10 -> busy drops next edge, done never asserts, HI stays 0x12345678, LO unchanged. Then start again -> LO=0x0000000F.
- start pulses while busy and hi_we=1 mid-op -> ignored: one done, result correct. Reset=0 mid-DIV -> all outputs 0 asynchronously; after release, IDLE and busy=0.
- WIDTH=8 instance, MULT 0x80*0x80 -> HI=0x40, LO=0x00, done after 10 edges.
